// File: rtl/preg_reclaim.sv
// Staging queue that frees stale physical tags from two retire slots into the free list, one per cycle.
// Optional duplicate-free detection with pending bitmap: define PREG_RECLAIM_DUP_CHECK_EN.
module preg_reclaim #(
  parameter int NUM_PREGS   = 128,
  parameter int STAGE_DEPTH = 4,
  localparam int TW = $clog2(NUM_PREGS),
  localparam int CW = $clog2(STAGE_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    ret_valid,
  input  logic [1:0]    ret_has_dest,
  input  logic [2*TW-1:0] ret_old_preg,
  output logic          ret_ready,
  output logic          fl_w_en,
  output logic [TW-1:0] fl_data,
  input  logic          fl_full,
  output logic [CW-1:0] stage_count,
  output logic          dbl_free_err
);
  localparam int PW = $clog2(STAGE_DEPTH);

  logic [TW-1:0] mem [STAGE_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, wr_ptr1;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tag0, tag1;
  logic          acc0, acc1, enq0, enq1, drop0, drop1, pop;

  assign tag0 = ret_old_preg[TW-1:0];
  assign tag1 = ret_old_preg[2*TW-1:TW];

  // Readiness ignores a same-cycle pop so acceptance never depends on fl_full.
  assign ret_ready   = (cnt <= CW'(STAGE_DEPTH - 2));
  assign pop         = (cnt != '0) & ~fl_full;
  assign fl_w_en     = pop;
  assign fl_data     = mem[rd_ptr];
  assign stage_count = cnt;

  assign acc0 = ret_valid[0] & ret_has_dest[0] & ret_ready;
  assign acc1 = ret_valid[1] & ret_has_dest[1] & ret_ready;

`ifdef PREG_RECLAIM_DUP_CHECK_EN
  logic [NUM_PREGS-1:0] pending, pend_eff;
  logic                 err_q;

  // The popping head no longer counts as pending, so it may be re-freed this cycle.
  always_comb begin
    pend_eff = pending;
    if (pop) pend_eff[fl_data] = 1'b0;
  end

  assign drop0 = acc0 & pend_eff[tag0];
  assign drop1 = acc1 & (pend_eff[tag1] | (acc0 & (tag1 == tag0)));

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      err_q   <= 1'b0;
    end else begin
      if (pop)  pending[fl_data] <= 1'b0;
      if (enq0) pending[tag0]    <= 1'b1;
      if (enq1) pending[tag1]    <= 1'b1;
      err_q <= drop0 | drop1;
    end
  end

  assign dbl_free_err = err_q;
`else
  assign drop0        = 1'b0;
  assign drop1        = 1'b0;
  assign dbl_free_err = 1'b0;
`endif

  assign enq0    = acc0 & ~drop0;
  assign enq1    = acc1 & ~drop1;
  // Slot 1 lands right after slot 0, or in slot 0's place when slot 0 is not enqueued.
  assign wr_ptr1 = wr_ptr + PW'(enq0);

  always_ff @(posedge clk) begin
    if (enq0) mem[wr_ptr]  <= tag0;
    if (enq1) mem[wr_ptr1] <= tag1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      wr_ptr <= wr_ptr + PW'(enq0) + PW'(enq1);
      cnt    <= cnt + CW'(enq0) + CW'(enq1) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_preg_reclaim.sv
// Self-checking bench for preg_reclaim: queue-based model compared every cycle plus literal checks.
module tb_preg_reclaim;
  localparam int TW    = 7;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    ret_valid = '0;
  logic [1:0]    ret_has_dest = '0;
  logic [2*TW-1:0] ret_old_preg = '0;
  logic          ret_ready;
  logic          fl_w_en;
  logic [TW-1:0] fl_data;
  logic          fl_full = 1'b0;
  logic [CW-1:0] stage_count;
  logic          dbl_free_err;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  int q[$];
  int m_err = 0;
  int dut_log[$];
  int exp_log[$];

  preg_reclaim #(.NUM_PREGS(128), .STAGE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_has_dest(ret_has_dest),
    .ret_old_preg(ret_old_preg), .ret_ready(ret_ready), .fl_w_en(fl_w_en),
    .fl_data(fl_data), .fl_full(fl_full), .stage_count(stage_count),
    .dbl_free_err(dbl_free_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_q(input int t);
    foreach (q[i]) if (q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  // Model: a tag list; pop the oldest when not full, then append accepted tags.
  always @(posedge clk) begin
    int t[2];
    int acc0_tag;
    bit ready, drop, any_drop, acc0;
    t[0] = int'(ret_old_preg[TW-1:0]);
    t[1] = int'(ret_old_preg[2*TW-1:TW]);
    if (chk_en && !rst && fl_w_en) dut_log.push_back(int'(fl_data));
    if (rst) begin
      q.delete();
      m_err = 0;
    end else begin
      ready = (DEPTH - q.size()) >= 2;
      if (q.size() != 0 && !fl_full) exp_log.push_back(q.pop_front());
      any_drop = 1'b0;
      acc0 = 1'b0;
      acc0_tag = -1;
      for (int s = 0; s < 2; s++) begin
        if (ret_valid[s] && ret_has_dest[s] && ready) begin
          drop = 1'b0;
`ifdef PREG_RECLAIM_DUP_CHECK_EN
          drop = in_q(t[s]) || (s == 1 && acc0 && acc0_tag == t[1]);
`endif
          if (s == 0) begin
            acc0 = 1'b1;
            acc0_tag = t[0];
          end
          if (drop) any_drop = 1'b1;
          else q.push_back(t[s]);
        end
      end
      m_err = any_drop ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stage_count", int'(stage_count), q.size());
      chk("ret_ready", int'(ret_ready), ((DEPTH - q.size()) >= 2) ? 1 : 0);
      chk("fl_w_en", int'(fl_w_en), (q.size() != 0 && !fl_full) ? 1 : 0);
      if (q.size() != 0) chk("fl_data", int'(fl_data), q[0]);
      chk("dbl_free_err", int'(dbl_free_err), m_err);
    end
  end

  task automatic cyc(input logic [1:0] v, input logic [1:0] h,
                     input int t0, input int t1, input logic full);
    ret_valid    = v;
    ret_has_dest = h;
    ret_old_preg = {TW'(t1), TW'(t0)};
    fl_full      = full;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'b00, 2'b00, 0, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    cyc(2'b00, 2'b00, 0, 0, 1'b0);
    cyc(2'b00, 2'b00, 0, 0, 1'b0);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_count", int'(stage_count), 0);
    chk("rst_ready", int'(ret_ready), 1);
    chk("rst_wen", int'(fl_w_en), 0);
    chk("rst_err", int'(dbl_free_err), 0);

    // Two tags in one cycle drain in order.
    cyc(2'b11, 2'b11, 5, 9, 1'b0);
    chk("basic_c1_cnt", int'(stage_count), 2);
    chk("basic_c1_wen", int'(fl_w_en), 1);
    chk("basic_c1_data", int'(fl_data), 5);
    cyc(2'b00, 2'b00, 0, 0, 1'b0);
    chk("basic_c2_cnt", int'(stage_count), 1);
    chk("basic_c2_data", int'(fl_data), 9);
    cyc(2'b00, 2'b00, 0, 0, 1'b0);
    chk("basic_c3_cnt", int'(stage_count), 0);
    chk("basic_c3_wen", int'(fl_w_en), 0);

    // Backpressure fills the queue; the third pair is refused.
    cyc(2'b11, 2'b11, 20, 21, 1'b1);
    chk("bp_cnt2_ready", int'(ret_ready), 1);
    cyc(2'b11, 2'b11, 22, 23, 1'b1);
    cyc(2'b11, 2'b11, 24, 25, 1'b1);
    chk("bp_cnt", int'(stage_count), 4);
    chk("bp_ready", int'(ret_ready), 0);
    chk("bp_wen", int'(fl_w_en), 0);
    ret_valid = 2'b00;
    fl_full   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_drain_data", int'(fl_data), 20 + i);
      chk("bp_drain_wen", int'(fl_w_en), 1);
      cyc(2'b00, 2'b00, 0, 0, 1'b0);
    end
    chk("bp_empty", int'(stage_count), 0);

    // Slot 1 alone, then slot 0 only with has_dest.
    cyc(2'b10, 2'b10, 99, 17, 1'b0);
    chk("s1_only_cnt", int'(stage_count), 1);
    chk("s1_only_data", int'(fl_data), 17);
    cyc(2'b11, 2'b01, 40, 41, 1'b0);
    chk("s0_hd_cnt", int'(stage_count), 1);
    chk("s0_hd_data", int'(fl_data), 40);
    idle(2);

    // Reset with three staged tags discards them.
    cyc(2'b11, 2'b11, 50, 51, 1'b1);
    cyc(2'b01, 2'b01, 52, 0, 1'b1);
    chk("pre_rst_cnt", int'(stage_count), 3);
    rst = 1'b1;
    cyc(2'b00, 2'b00, 0, 0, 1'b0);
    rst = 1'b0;
    chk("mid_rst_cnt", int'(stage_count), 0);
    chk("mid_rst_wen", int'(fl_w_en), 0);
    idle(3);

    // Random traffic across pointer wrap.
    for (int i = 0; i < 40; i++)
      cyc(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          $urandom_range(0, 127), $urandom_range(0, 127), 1'($urandom_range(0, 3) == 0));
    idle(6);

    // Duplicate tag in both slots.
    cyc(2'b11, 2'b11, 33, 33, 1'b0);
`ifdef PREG_RECLAIM_DUP_CHECK_EN
    chk("dup_cnt", int'(stage_count), 1);
    chk("dup_err", int'(dbl_free_err), 1);
    cyc(2'b00, 2'b00, 0, 0, 1'b0);
    chk("dup_err_clr", int'(dbl_free_err), 0);
`else
    chk("dup_cnt", int'(stage_count), 2);
    chk("dup_err", int'(dbl_free_err), 0);
    chk("dup_data0", int'(fl_data), 33);
    cyc(2'b00, 2'b00, 0, 0, 1'b0);
    chk("dup_data1", int'(fl_data), 33);
`endif
    idle(3);

    // Pop and re-free of the same tag in one cycle.
    cyc(2'b01, 2'b01, 60, 0, 1'b0);
    cyc(2'b01, 2'b01, 60, 0, 1'b0);
    chk("refree_cnt", int'(stage_count), 1);
    chk("refree_err", int'(dbl_free_err), 0);
    idle(3);

    chk("log_len", dut_log.size(), exp_log.size());
    for (int i = 0; i < dut_log.size() && i < exp_log.size(); i++)
      if (dut_log[i] != exp_log[i]) chk("log_entry", dut_log[i], exp_log[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/preg_reclaim.md
PREG_RECLAIM -- requirements
Module: preg_reclaim

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- NUM_PREGS, 128, physical register count; tag width TW = $clog2(NUM_PREGS) = 7.
- STAGE_DEPTH, 4, staging queue entries; power of 2, minimum 2.

REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst, in, 1, synchronous active-high reset.
- ret_valid, in, 2, per-slot retire valid; slot 0 is older.
- ret_has_dest, in, 2, per-slot flag: the retiring instruction overwrote a mapping.
- ret_old_preg, in, 2xTW, per-slot stale physical tag to free.
- ret_ready, out, 1, the block can accept both retire slots this cycle.
- fl_w_en, out, 1, push strobe to the free-list FIFO.
- fl_data, out, TW, tag pushed to the free list.
- fl_full, in, 1, free-list full indication.
- stage_count, out, $clog2(STAGE_DEPTH)+1, current staging occupancy.
- dbl_free_err, out, 1, double-free detected (see Configuration).

REQ-003 Clocking and reset SHALL be one clock (clk) and a synchronous, active-high reset (rst); all state updates on posedge clk.

Function
REQ-004 A slot SHALL be accepted when ret_valid[i] & ret_has_dest[i] & ret_ready; slots lacking either flag are ignored.
REQ-005 Accepted slots SHALL be enqueued in order: slot 0 before slot 1. Slot 1 alone (slot 0 invalid) SHALL enqueue as a single entry.
REQ-006 ret_ready SHALL be combinational from registered state: high iff (STAGE_DEPTH - stage_count) >= 2. It SHALL NOT credit a same-cycle pop.
REQ-007 fl_w_en SHALL be (stage_count != 0) & !fl_full, and fl_data SHALL equal the head entry. When fl_w_en is high, the head SHALL pop in the same cycle.
REQ-008 At most one tag SHALL be pushed per cycle.
REQ-009 Minimum latency SHALL be one cycle: a tag accepted in cycle N SHALL appear on fl_data no earlier than cycle N+1.
REQ-010 Simultaneous pop and enqueue of up to 2 entries SHALL be legal. stage_count(next) = stage_count + accepted - popped.
REQ-011 Read and write pointers SHALL be $clog2(STAGE_DEPTH) bits and wrap modulo STAGE_DEPTH. Full and empty SHALL be derived from stage_count, never from pointer equality.
REQ-012 While fl_full is high, the head SHALL hold stable and fl_w_en SHALL stay 0. Enqueue SHALL continue until ret_ready drops.
REQ-013 Overflow SHALL be impossible given REQ-006. Tags SHALL never be dropped, reordered, or duplicated, except as stated in REQ-017.

Reset
REQ-014 On rst, the block SHALL clear both pointers and stage_count and set dbl_free_err=0; fl_w_en SHALL be 0 in the following cycle.
REQ-015 Reset mid-operation SHALL discard all staged tags with no push. The free list reinitialises in the same reset, so this is consistent.
REQ-016 Outputs after reset SHALL be: ret_ready=1, fl_w_en=0, fl_data=don't-care, stage_count=0.

Configuration
REQ-017 With macro PREG_RECLAIM_DUP_CHECK_EN defined, the block SHALL behave as follows:
- It SHALL keep a NUM_PREGS-bit pending bitmap: set on enqueue, cleared on pop.
- An accepted tag whose bit is already set, or slot 1 equal to slot 0 in the same cycle, SHALL be dropped (not enqueued).
- Each such drop SHALL pulse dbl_free_err high for exactly one cycle, in the cycle after acceptance.
- A pop and a re-enqueue of the same tag in one cycle SHALL NOT flag an error.
REQ-018 Without PREG_RECLAIM_DUP_CHECK_EN, the block SHALL have no bitmap, dbl_free_err SHALL be tied 0, and duplicates SHALL be enqueued normally.

Verification
REQ-019 Reset, then ret_valid=2'b11, has_dest=2'b11, tags 5 and 9 in cycle 0 -> cycle 1: fl_data=5 with fl_w_en=1; cycle 2: fl_data=9; stage_count 2,1,0.
REQ-020 fl_full=1 held for 3 cycles while 2 tags are accepted per cycle -> stage_count reaches 4, ret_ready=0, fl_w_en=0. Release fl_full -> tags drain one per cycle in acceptance order.
REQ-021 ret_valid=2'b10 with tag 17, plus ret_valid=2'b11 with has_dest=2'b01 -> only the slot-1 tag 17 and the slot-0 tag enqueue; no entry for the slot without has_dest.
REQ-022 Assert rst while stage_count=3 -> next cycle stage_count=0, fl_w_en=0, no stale tag is ever pushed afterwards.
REQ-023 Drive 40 random cycles across pointer wrap -> the pushed sequence equals the accepted sequence exactly (scoreboard).
REQ-024 With PREG_RECLAIM_DUP_CHECK_EN, both slots carry tag 33 -> a single 33 is pushed and dbl_free_err=1 for one cycle. Without the macro -> 33 is pushed twice and dbl_free_err=0.
